// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: round-robin debounce of NKEYS active-low buttons feeding an event FIFO.
// Optional build macro KEY_REPEAT_EN adds auto-repeat events for held keys.
module key_scan_ctrl #(
  parameter int NKEYS      = 4,
  parameter int PRESC      = 50000,
  parameter int DEB_TICKS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_DELAY  = 500,
  parameter int REP_RATE   = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NKEYS-1:0]         btn,
  output logic [NKEYS-1:0]         state,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [$clog2(NKEYS)-1:0] ev_key,
  output logic                     ev_press,
  output logic                     ev_rep,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int KW = $clog2(NKEYS);
  localparam int PW = $clog2(PRESC);
  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  if (NKEYS < 2 || NKEYS > 16 || PRESC < 2 ||
      DEB_TICKS < 1 || DEB_TICKS > 255 ||
      FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      REP_DELAY < 1 || REP_RATE < 1) begin : g_bad_param
    $error("key_scan_ctrl: illegal parameter set");
  end

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } st_t;

  typedef struct packed {
    logic          rep;
    logic          press;
    logic [KW-1:0] key;
  } ev_t;

  logic [NKEYS-1:0] r_s1;
  logic [NKEYS-1:0] r_s2;
  logic [PW-1:0]    r_pc;
  st_t              r_st;
  st_t              w_st_nxt;
  logic [KW-1:0]    r_idx;
  logic [KW-1:0]    w_idx_nxt;
  logic             w_tick;
  logic             w_last;
  logic             w_scan;

  logic [NKEYS-1:0] r_state;
  logic [CW-1:0]    r_cnt [NKEYS];
  logic             w_sk;
  logic             w_st;
  logic [CW-1:0]    w_ck;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_tog;
  logic             w_rpush;
  logic             w_push_req;
  ev_t              w_ev;

  ev_t              r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             r_ovf;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;
  logic             w_drop;
  ev_t              w_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= ~btn;
      r_s2 <= r_s1;
    end
  end

  assign w_tick = (r_pc == PW'(PRESC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else if (w_tick) begin
      r_pc <= '0;
    end else begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign w_last = (r_idx == KW'(NKEYS - 1));

  // A tick landing on the last key restarts the scan so no tick is lost.
  always_comb begin
    w_st_nxt  = r_st;
    w_idx_nxt = r_idx;
    w_scan    = 1'b0;
    case (r_st)
      S_IDLE: begin
        w_idx_nxt = '0;
        if (w_tick) begin
          w_st_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        w_scan = 1'b1;
        if (w_last) begin
          w_idx_nxt = '0;
          w_st_nxt  = w_tick ? S_SCAN : S_IDLE;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_st_nxt  = S_IDLE;
        w_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st  <= S_IDLE;
      r_idx <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  assign w_sk = r_s2[r_idx];
  assign w_st = r_state[r_idx];
  assign w_ck = r_cnt[r_idx];

  always_comb begin
    w_cnt_nxt = '0;
    w_tog     = 1'b0;
    if (w_sk != w_st) begin
      if (w_ck == CW'(DEB_TICKS - 1)) begin
        w_tog = 1'b1;
      end else begin
        w_cnt_nxt = w_ck + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_scan) begin
      r_cnt[r_idx] <= w_cnt_nxt;
      if (w_tog) begin
        r_state[r_idx] <= ~w_st;
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0]    r_rcnt [NKEYS];
  logic [NKEYS-1:0] r_ron;
  logic [RW-1:0]    w_rcnt_nxt;
  logic             w_ron_nxt;

  // r_ron marks that the first repeat fired; later repeats use REP_RATE.
  always_comb begin
    w_rcnt_nxt = '0;
    w_ron_nxt  = 1'b0;
    w_rpush    = 1'b0;
    if (w_st && (w_sk == w_st) && (w_ck == '0)) begin
      w_rcnt_nxt = r_rcnt[r_idx] + 1'b1;
      w_ron_nxt  = r_ron[r_idx];
      if (r_ron[r_idx] ? (w_rcnt_nxt == RW'(REP_RATE))
                       : (w_rcnt_nxt == RW'(REP_DELAY))) begin
        w_rpush    = 1'b1;
        w_rcnt_nxt = '0;
        w_ron_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ron <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        r_rcnt[i] <= '0;
      end
    end else if (w_scan) begin
      r_rcnt[r_idx] <= w_rcnt_nxt;
      r_ron[r_idx]  <= w_ron_nxt;
    end
  end
`else
  assign w_rpush = 1'b0;
`endif

  assign w_push_req = w_scan & (w_tog | w_rpush);

  always_comb begin
    w_ev       = '0;
    w_ev.key   = r_idx;
    w_ev.press = w_tog ? ~w_st : 1'b1;
    w_ev.rep   = ~w_tog;
  end

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = ~w_empty & ev_ready;
  assign w_wr    = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & ~w_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wp[AW-1:0]] <= w_ev;
        r_wp                <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign w_head   = r_mem[r_rp[AW-1:0]];
  assign state    = r_state;
  assign overflow = r_ovf;
  assign ev_valid = ~w_empty;
  assign ev_key   = w_empty ? '0 : w_head.key;
  assign ev_press = w_empty ? 1'b0 : w_head.press;
  assign ev_rep   = w_empty ? 1'b0 : w_head.rep;

endmodule
